// File: rtl/lcd_timing_gen_pkg.sv
// Shared timing sets, FSM encoding and sizing helper for the LCD timing generator.
package lcd_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t VGA_640x480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t WVGA_800x480 = '{800, 40, 128, 88, 480, 13, 3, 29};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) result = i + 1;
        return result;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel-source bus: coordinate requests out of the generator, colour data back in.
interface lcd_timing_gen_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 6
);
    logic               req_valid;
    logic [X_W-1:0]     req_x;
    logic [Y_W-1:0]     req_y;
    logic               frame_start;
    logic               line_start;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    modport master (
        output req_valid, req_x, req_y, frame_start, line_start,
        input  red, green, blue
    );

    modport slave (
        input  req_valid, req_x, req_y, frame_start, line_start,
        output red, green, blue
    );
endinterface

// File: rtl/lcd_delay_line.sv
// Enable-gated shift register; DEPTH of 0 degenerates to a wire.
module lcd_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk50, rst_n, enable};
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] taps [DEPTH];

        always_ff @(posedge clk50) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
            end else if (enable) begin
                taps[0] <= din;
                for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            end
        end

        assign dout = taps[DEPTH-1];
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB TFT timing generator with latency-matched pixel requests.
// state | meaning
// IDLE  | counters parked at 0, no requests, syncs inactive
// SCAN  | counters free-run over the full frame, requests issued in active area
// DRAIN | frame finished with run low; flushing the PIPE_LAT+1 display pipeline
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_640x480.h_active,
    parameter int H_FP      = VGA_640x480.h_fp,
    parameter int H_SYNC    = VGA_640x480.h_sync,
    parameter int H_BP      = VGA_640x480.h_bp,
    parameter int V_ACTIVE  = VGA_640x480.v_active,
    parameter int V_FP      = VGA_640x480.v_fp,
    parameter int V_SYNC    = VGA_640x480.v_sync,
    parameter int V_BP      = VGA_640x480.v_bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = 6,
    parameter int PIPE_LAT  = 2
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               run,
    lcd_timing_gen_if.master   pix,
    output logic               busy,
    output logic               PIN_CLK,
    output logic               PIN_HSYNC,
    output logic               PIN_VSYNC,
    output logic               PIN_DEN,
    output logic [COLOR_W-1:0] PIN_RED,
    output logic [COLOR_W-1:0] PIN_GREEN,
    output logic [COLOR_W-1:0] PIN_BLUE,
    output logic               PIN_REV,
    output logic               PIN_DISP
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_CW    = clog2(H_TOTAL) + 1;
    localparam int V_CW    = clog2(V_TOTAL) + 1;
    localparam int X_W     = clog2(H_ACTIVE);
    localparam int Y_W     = clog2(V_ACTIVE);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SCAN  = ST_SCAN;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]      state;
    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic [3:0]      drain_cnt;
    logic            h_last, v_last, scan;
    logic            stage_den, stage_hs, stage_vs;
    logic            dl_den, dl_hs, dl_vs;

    assign h_last = (h_cnt == H_CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == V_CW'(V_TOTAL - 1));
    assign scan   = (state == SCAN);

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            drain_cnt <= '0;
        end else if (enable) begin
            case (state)
                IDLE: if (run) state <= SCAN;
                SCAN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (!run) begin
                                state     <= DRAIN;
                                drain_cnt <= 4'(PIPE_LAT);
                            end
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= IDLE;
                    else                 drain_cnt <= drain_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counter-stage view; requests are only issued while scanning, never while draining.
    assign stage_den = scan && (h_cnt < H_CW'(H_ACTIVE)) && (v_cnt < V_CW'(V_ACTIVE));
    assign stage_hs  = scan && (h_cnt >= H_CW'(H_ACTIVE + H_FP))
                            && (h_cnt <  H_CW'(H_ACTIVE + H_FP + H_SYNC));
    assign stage_vs  = scan && (v_cnt >= V_CW'(V_ACTIVE + V_FP))
                            && (v_cnt <  V_CW'(V_ACTIVE + V_FP + V_SYNC));

    assign pix.req_valid   = stage_den;
    assign pix.req_x       = stage_den ? h_cnt[X_W-1:0] : '0;
    assign pix.req_y       = stage_den ? v_cnt[Y_W-1:0] : '0;
    assign pix.frame_start = stage_den && (h_cnt == '0) && (v_cnt == '0);
    assign pix.line_start  = stage_den && (h_cnt == '0);

    assign busy     = (state != IDLE);
    assign PIN_CLK  = enable;
    assign PIN_REV  = 1'b1;
    assign PIN_DISP = 1'b1;

    lcd_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_align (
        .clk50  (clk50),
        .rst_n  (rst_n),
        .enable (enable),
        .din    ({stage_den, stage_hs, stage_vs}),
        .dout   ({dl_den, dl_hs, dl_vs})
    );

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            PIN_DEN   <= 1'b0;
            PIN_HSYNC <= ~HSYNC_POL;
            PIN_VSYNC <= ~VSYNC_POL;
            PIN_RED   <= '0;
            PIN_GREEN <= '0;
            PIN_BLUE  <= '0;
        end else if (enable) begin
            PIN_DEN   <= dl_den;
            PIN_HSYNC <= dl_hs ? HSYNC_POL : ~HSYNC_POL;
            PIN_VSYNC <= dl_vs ? VSYNC_POL : ~VSYNC_POL;
            PIN_RED   <= dl_den ? pix.red   : '0;
            PIN_GREEN <= dl_den ? pix.green : '0;
            PIN_BLUE  <= dl_den ? pix.blue  : '0;
        end
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Runs five generator configurations in lockstep against a frame-position reference model.
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    localparam int NI = 5;
    localparam int T_HA [NI] = '{640, 8, 8, 8, 8};
    localparam int T_HF [NI] = '{16, 2, 2, 2, 2};
    localparam int T_HS [NI] = '{96, 2, 2, 2, 2};
    localparam int T_HB [NI] = '{48, 2, 2, 2, 2};
    localparam int T_VA [NI] = '{480, 4, 4, 4, 4};
    localparam int T_VF [NI] = '{10, 1, 1, 1, 1};
    localparam int T_VS [NI] = '{2, 1, 1, 1, 1};
    localparam int T_VB [NI] = '{33, 1, 1, 1, 1};
    localparam int T_L  [NI] = '{2, 0, 2, 5, 2};
    localparam int T_HP [NI] = '{0, 0, 0, 0, 1};
    localparam int T_VP [NI] = '{0, 0, 0, 0, 1};

    typedef struct packed {
        logic       den;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
    } tup_t;

    logic clk50  = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic run    = 1'b0;

    logic [47:0] obs [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   m_mode [NI];
    int   m_n    [NI];
    int   m_dc   [NI];
    tup_t hist   [NI][16];

    always #10 clk50 = ~clk50;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LI = (T_L[g] == 0) ? 0 : T_L[g] - 1;

        lcd_timing_gen_if #(
            .X_W     (clog2(T_HA[g])),
            .Y_W     (clog2(T_VA[g])),
            .COLOR_W (6)
        ) bus ();

        logic       busy_o, pclk, hs, vs, den, rev, disp;
        logic [5:0] pr, pg, pb;
        logic [9:0] sx [16];
        logic [9:0] sy [16];
        logic [9:0] src_x, src_y;

        lcd_timing_gen #(
            .H_ACTIVE  (T_HA[g]),
            .H_FP      (T_HF[g]),
            .H_SYNC    (T_HS[g]),
            .H_BP      (T_HB[g]),
            .V_ACTIVE  (T_VA[g]),
            .V_FP      (T_VF[g]),
            .V_SYNC    (T_VS[g]),
            .V_BP      (T_VB[g]),
            .HSYNC_POL (1'(T_HP[g])),
            .VSYNC_POL (1'(T_VP[g])),
            .COLOR_W   (6),
            .PIPE_LAT  (T_L[g])
        ) dut (
            .clk50     (clk50),
            .rst_n     (rst_n),
            .enable    (enable),
            .run       (run),
            .pix       (bus),
            .busy      (busy_o),
            .PIN_CLK   (pclk),
            .PIN_HSYNC (hs),
            .PIN_VSYNC (vs),
            .PIN_DEN   (den),
            .PIN_RED   (pr),
            .PIN_GREEN (pg),
            .PIN_BLUE  (pb),
            .PIN_REV   (rev),
            .PIN_DISP  (disp)
        );

        // Pixel source with T_L[g] ticks of latency, colour derived from the coordinate.
        always @(posedge clk50) begin
            if (enable) begin
                sx[0] <= 10'(bus.req_x);
                sy[0] <= 10'(bus.req_y);
                for (int k = 1; k < 16; k++) begin
                    sx[k] <= sx[k-1];
                    sy[k] <= sy[k-1];
                end
            end
        end

        assign src_x     = (T_L[g] == 0) ? 10'(bus.req_x) : sx[LI];
        assign src_y     = (T_L[g] == 0) ? 10'(bus.req_y) : sy[LI];
        assign bus.red   = src_x[5:0];
        assign bus.green = src_y[5:0];
        assign bus.blue  = 6'(src_x + src_y);

        assign obs[g] = {busy_o, bus.req_valid, 10'(bus.req_x), 10'(bus.req_y),
                         bus.frame_start, bus.line_start, pclk, hs, vs, den,
                         pr, pg, pb, rev, disp};
    end

    function automatic int frame_len(int i);
        return (T_HA[i] + T_HF[i] + T_HS[i] + T_HB[i]) *
               (T_VA[i] + T_VF[i] + T_VS[i] + T_VB[i]);
    endfunction

    // Counter-stage view of frame position n while in the given mode.
    function automatic tup_t mk(int i, int mode, int n);
        tup_t t;
        int   ht = T_HA[i] + T_HF[i] + T_HS[i] + T_HB[i];
        int   h  = n % ht;
        int   v  = n / ht;
        bit   s  = (mode == 1);
        t.den = s && (h < T_HA[i]) && (v < T_VA[i]);
        t.hs  = s && (h >= T_HA[i] + T_HF[i]) && (h < T_HA[i] + T_HF[i] + T_HS[i]);
        t.vs  = s && (v >= T_VA[i] + T_VF[i]) && (v < T_VA[i] + T_VF[i] + T_VS[i]);
        t.x   = t.den ? 10'(h) : '0;
        t.y   = t.den ? 10'(v) : '0;
        return t;
    endfunction

    function automatic logic [47:0] expect_vec(int i);
        tup_t c  = mk(i, m_mode[i], m_n[i]);
        tup_t d  = hist[i][T_L[i]];
        logic hp = (T_HP[i] != 0);
        logic vp = (T_VP[i] != 0);
        return {(m_mode[i] != 0), c.den, c.x, c.y,
                c.den && (c.x == '0) && (c.y == '0), c.den && (c.x == '0),
                enable, d.hs ? hp : !hp, d.vs ? vp : !vp, d.den,
                d.den ? d.x[5:0] : 6'd0, d.den ? d.y[5:0] : 6'd0,
                d.den ? 6'(d.x + d.y) : 6'd0, 1'b1, 1'b1};
    endfunction

    task automatic model_update(input logic en, input logic rv, input logic rb);
        for (int i = 0; i < NI; i++) begin
            if (!rb) begin
                m_mode[i] = 0;
                m_n[i]    = 0;
                m_dc[i]   = 0;
                for (int j = 0; j < 16; j++) hist[i][j] = '0;
            end else if (en) begin
                for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = mk(i, m_mode[i], m_n[i]);
                case (m_mode[i])
                    0: if (rv) begin
                        m_mode[i] = 1;
                        m_n[i]    = 0;
                    end
                    1: if ((m_n[i] == frame_len(i) - 1) && !rv) begin
                        m_mode[i] = 2;
                        m_dc[i]   = T_L[i] + 1;
                        m_n[i]    = 0;
                    end else begin
                        m_n[i] = (m_n[i] + 1) % frame_len(i);
                    end
                    default: if (m_dc[i] == 1) m_mode[i] = 0;
                             else              m_dc[i]   = m_dc[i] - 1;
                endcase
            end
        end
    endtask

    task automatic tick(input logic en, input logic rv, input logic rb);
        logic [47:0] exp_v;
        @(negedge clk50);
        enable = en;
        run    = rv;
        rst_n  = rb;
        @(posedge clk50);
        #1;
        cyc++;
        model_update(en, rv, rb);
        for (int i = 0; i < NI; i++) begin
            exp_v = expect_vec(i);
            checks++;
            assert (obs[i] === exp_v) else begin
                failures++;
                $error("FAIL outputs inst%0d cycle%0d observed=%h expected=%h",
                       i, cyc, obs[i], exp_v);
            end
        end
    endtask

    initial begin
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 1'b1);
        repeat (300) tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 400; k++) tick((k % 4) == 0, 1'b1, 1'b1);
        repeat (200) tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 60; k++) tick((k % 4) == 0, 1'b0, 1'b1);
        repeat (150) tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        repeat (150) tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 600; k++) tick((k % 4) == 0, k < 300, 1'b1);
        repeat (1500) tick(($urandom % 4) != 0, ($urandom % 2) == 1, 1'b1);
        repeat (1500) tick(($urandom % 2) == 1, ($urandom % 8) != 0, ($urandom % 300) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
